// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Unified memory bus between the IF/MEM arbiter and the memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_be,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_be,
        output bus_ready,
        output bus_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares the unified memory bus between IF and MEM (MEM priority),
//            steers store lanes and raises per-stage stalls. Macro
//            ARB_TIMEOUT_EN enables aborting accesses after TIMEOUT_CYCLES.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        if_req_i,
    input  wire logic [31:0] if_addr_i,
    input  wire logic        mem_req_i,
    input  wire logic        mem_we_i,
    input  wire logic [31:0] mem_addr_i,
    input  wire logic [31:0] mem_wdata_i,
    input  wire logic [1:0]  mem_size_i,
    mem_port_arbiter_if.master bus_if,
    output logic             if_done_o,
    output logic [31:0]      if_rdata_o,
    output logic             mem_done_o,
    output logic [31:0]      mem_rdata_o,
    output logic             misalign_err_o,
    output logic             bus_err_o,
    output logic             stall_if_o,
    output logic             stall_mem_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        w_if_pend;
    logic        w_mem_pend;
    logic        w_mem_misaligned;
    logic [3:0]  w_mem_be;
    logic [31:0] w_mem_lane_wdata;
    logic        w_abort;
    logic        w_end;
    logic        w_arb;
    logic        w_cand_if;
    logic        w_cand_mem;
    logic        w_grant;
    logic        w_unused_addr_bits;

    // A requester whose done is pulsing this cycle still holds its request;
    // masking it here prevents a second service of the same request.
    assign w_if_pend  = if_req_i  & ~if_done_q;
    assign w_mem_pend = mem_req_i & ~mem_done_q;

    assign w_unused_addr_bits = ^if_addr_i[1:0];

    always_comb begin
        w_mem_misaligned = 1'b0;
        w_mem_be         = 4'b1111;
        w_mem_lane_wdata = mem_wdata_i;
        case (mem_size_i)
            2'b00: begin
                w_mem_be         = 4'b0001 << mem_addr_i[1:0];
                w_mem_lane_wdata = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                w_mem_misaligned = mem_addr_i[0];
                w_mem_be         = 4'b0011 << {mem_addr_i[1], 1'b0};
                w_mem_lane_wdata = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                w_mem_misaligned = |mem_addr_i[1:0];
            end
        endcase
        if (!mem_we_i) begin
            w_mem_be = 4'b1111;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_LAST_WAIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Abort on the wait cycle that would bring the count to TIMEOUT_CYCLES,
    // so bus_req is low in the following cycle together with the done pulse.
    assign w_abort = (state_q != IDLE) && !bus_if.bus_ready && (wait_cnt_q == c_LAST_WAIT);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_q != IDLE) && !bus_if.bus_ready) begin
            wait_cnt_d = wait_cnt_q + c_CNT_W'(1);
        end
        if (w_grant) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES < 1);
    assign w_abort          = 1'b0;
`endif

    assign w_end = bus_if.bus_ready | w_abort;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        w_arb       = 1'b0;
        w_cand_if   = 1'b0;
        w_cand_mem  = 1'b0;
        w_grant     = 1'b0;

        case (state_q)
            IDLE: begin
                w_arb      = 1'b1;
                w_cand_if  = w_if_pend;
                w_cand_mem = w_mem_pend;
            end
            GNT_IF: begin
                if (w_end) begin
                    w_arb      = 1'b1;
                    w_cand_mem = w_mem_pend;
                    if_done_d  = 1'b1;
                    bus_err_d  = w_abort;
                    if_rdata_d = w_abort ? 32'd0 : bus_if.bus_rdata;
                end
            end
            GNT_MEM: begin
                if (w_end) begin
                    w_arb       = 1'b1;
                    w_cand_if   = w_if_pend;
                    mem_done_d  = 1'b1;
                    bus_err_d   = w_abort;
                    mem_rdata_d = w_abort ? 32'd0 : bus_if.bus_rdata;
                end
            end
            default: begin
                w_arb = 1'b1;
            end
        endcase

        // Shared arbitration: entered from IDLE or on completion with the
        // served requester masked, giving a gapless hand-over.
        if (w_arb) begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
            if (w_cand_mem && !w_mem_misaligned) begin
                state_d     = GNT_MEM;
                bus_req_d   = 1'b1;
                bus_we_d    = mem_we_i;
                bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                bus_be_d    = w_mem_be;
                bus_wdata_d = w_mem_lane_wdata;
                w_grant     = 1'b1;
            end else if (w_cand_mem) begin
                mem_done_d = 1'b1;
                misalign_d = 1'b1;
            end else if (w_cand_if) begin
                state_d     = GNT_IF;
                bus_req_d   = 1'b1;
                bus_we_d    = 1'b0;
                bus_addr_d  = {if_addr_i[31:2], 2'b00};
                bus_be_d    = 4'b1111;
                bus_wdata_d = 32'd0;
                w_grant     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'b0000;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_if.bus_req   = bus_req_q;
    assign bus_if.bus_we    = bus_we_q;
    assign bus_if.bus_addr  = bus_addr_q;
    assign bus_if.bus_wdata = bus_wdata_q;
    assign bus_if.bus_be    = bus_be_q;

    assign if_done_o      = if_done_q;
    assign if_rdata_o     = if_rdata_q;
    assign mem_done_o     = mem_done_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign misalign_err_o = misalign_q;
    assign bus_err_o      = bus_err_q;
    assign stall_if_o     = if_req_i & ~if_done_q;
    assign stall_mem_o    = mem_req_i & ~mem_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter (bus and done responses).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        if_done, mem_done, misalign_err, bus_err, stall_if, stall_mem;
    logic [31:0] if_rdata, mem_rdata;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req),
        .if_addr_i      (if_addr),
        .mem_req_i      (mem_req),
        .mem_we_i       (mem_we),
        .mem_addr_i     (mem_addr),
        .mem_wdata_i    (mem_wdata),
        .mem_size_i     (mem_size),
        .bus_if         (bus.master),
        .if_done_o      (if_done),
        .if_rdata_o     (if_rdata),
        .mem_done_o     (mem_done),
        .mem_rdata_o    (mem_rdata),
        .misalign_err_o (misalign_err),
        .bus_err_o      (bus_err),
        .stall_if_o     (stall_if),
        .stall_mem_o    (stall_mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        mis;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        int          start;
        logic [31:0] addr;
    } ifreq_t;

    typedef struct {
        int          start;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  size;
    } memreq_t;

    bus_t    exp_bus[$];
    rsp_t    exp_if[$];
    rsp_t    exp_mem[$];
    ifreq_t  if_reqs[$];
    memreq_t mem_reqs[$];

    int errors = 0;
    int checks = 0;
    int lat = 0;
    bit never_ready = 1'b0;
    int n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_bus_push(input logic [31:0] a, input logic we, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] rd);
        bus_t b;
        b.addr = a; b.we = we; b.be = be; b.wdata = wd; b.rdata = rd;
        exp_bus.push_back(b);
    endtask

    function automatic rsp_t mk_rsp(input logic [31:0] rd, input logic chkr, input logic mis,
                                    input logic err, input int c);
        rsp_t r;
        r.rdata = rd; r.chk_rdata = chkr; r.mis = mis; r.err = err; r.cyc = c;
        return r;
    endfunction

    task automatic req_if(input int start, input logic [31:0] a);
        ifreq_t q;
        q.start = start; q.addr = a;
        if_reqs.push_back(q);
    endtask

    task automatic req_mem(input int start, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [1:0] sz);
        memreq_t q;
        q.start = start; q.addr = a; q.we = we; q.wdata = wd; q.size = sz;
        mem_reqs.push_back(q);
    endtask

    task automatic to_pos(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic to_neg(input int c);
        to_pos(c);
        @(negedge clk);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 80 && (exp_bus.size() != 0 || exp_if.size() != 0 || exp_mem.size() != 0 ||
                          if_reqs.size() != 0 || mem_reqs.size() != 0 || if_req || mem_req)) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (i >= 80) begin
            errors++;
            $display("FAIL drain: outstanding bus=%0d if=%0d mem=%0d after %0d cycles, expected 0",
                     exp_bus.size(), exp_if.size(), exp_mem.size(), i);
            exp_bus.delete(); exp_if.delete(); exp_mem.delete();
        end
        @(negedge clk);
    endtask

    // IF requester: raises queued requests, drops one cycle after its done.
    initial begin
        ifreq_t t;
        logic   d;
        if_req  = 1'b0;
        if_addr = 32'd0;
        forever begin
            @(negedge clk);
            d = if_done;
            @(posedge clk);
            #1;
            if (rst) begin
                if_req = 1'b0;
            end else if (if_req && d) begin
                if_req = 1'b0;
            end else if (!if_req && if_reqs.size() != 0 && cyc >= if_reqs[0].start) begin
                t = if_reqs.pop_front();
                if_req  = 1'b1;
                if_addr = t.addr;
            end
        end
    end

    // MEM requester.
    initial begin
        memreq_t t;
        logic    d;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_size  = 2'b10;
        forever begin
            @(negedge clk);
            d = mem_done;
            @(posedge clk);
            #1;
            if (rst) begin
                mem_req = 1'b0;
            end else if (mem_req && d) begin
                mem_req = 1'b0;
            end else if (!mem_req && mem_reqs.size() != 0 && cyc >= mem_reqs[0].start) begin
                t = mem_reqs.pop_front();
                mem_req   = 1'b1;
                mem_we    = t.we;
                mem_addr  = t.addr;
                mem_wdata = t.wdata;
                mem_size  = t.size;
            end
        end
    end

    // Memory responder and bus-side monitor: ready after `lat` wait cycles.
    initial begin
        bus_t b;
        int   wcnt;
        wcnt = 0;
        bus.bus_ready = 1'b0;
        bus.bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.bus_req && !rst && !never_ready) begin
                if (wcnt >= lat) begin
                    if (exp_bus.size() == 0) begin
                        chk("bus_unexpected_access", bus.bus_addr, 32'hFFFF_FFFF);
                        bus.bus_rdata = 32'd0;
                    end else begin
                        b = exp_bus.pop_front();
                        chk("bus_addr", bus.bus_addr, b.addr);
                        chk("bus_we", {31'd0, bus.bus_we}, {31'd0, b.we});
                        chk("bus_be", {28'd0, bus.bus_be}, {28'd0, b.be});
                        if (b.we) chk("bus_wdata", bus.bus_wdata, b.wdata);
                        bus.bus_rdata = b.rdata;
                    end
                    bus.bus_ready = 1'b1;
                    wcnt = 0;
                end else begin
                    bus.bus_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.bus_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Done monitor: pops the scoreboard whenever a completion pulse appears.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst && if_done) begin
                if (exp_if.size() == 0) begin
                    chk("if_done_unexpected", 32'd1, 32'd0);
                end else begin
                    r = exp_if.pop_front();
                    if (r.chk_rdata) chk("if_rdata", if_rdata, r.rdata);
                    chk("if_bus_err", {31'd0, bus_err}, {31'd0, r.err});
                    chk("if_done_cycle", cyc, r.cyc);
                end
            end
            if (!rst && mem_done) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_done_unexpected", 32'd1, 32'd0);
                end else begin
                    r = exp_mem.pop_front();
                    if (r.chk_rdata) chk("mem_rdata", mem_rdata, r.rdata);
                    chk("mem_misalign_err", {31'd0, misalign_err}, {31'd0, r.mis});
                    chk("mem_bus_err", {31'd0, bus_err}, {31'd0, r.err});
                    chk("mem_done_cycle", cyc, r.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    logic [31:0] t_addr [7] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h108, 32'h104, 32'h102};
    logic        t_we   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] t_wd   [7] = '{32'h0000_00A5, 32'h0000_003C, 32'h1234_BEEF, 32'hABCD_0123,
                                32'hCAFE_F00D, 32'h0, 32'h0};
    logic [1:0]  t_sz   [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [3:0]  t_be   [7] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1111, 4'b1111};
    logic [31:0] t_bwd  [7] = '{32'hA5A5_A5A5, 32'h3C3C_3C3C, 32'hBEEF_BEEF, 32'h0123_0123,
                                32'hCAFE_F00D, 32'h0, 32'h0};

    logic [31:0] m_addr [4] = '{32'h101, 32'h103, 32'h102, 32'h101};
    logic        m_we   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  m_sz   [4] = '{2'b10, 2'b01, 2'b10, 2'b11};

    initial begin
        int lows;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
        chk("rst_bus_addr", bus.bus_addr, 32'd0);
        chk("rst_bus_be_we", {27'd0, bus.bus_be, bus.bus_we}, 32'd0);
        chk("rst_bus_wdata", bus.bus_wdata, 32'd0);
        chk("rst_dones", {26'd0, if_done, mem_done, misalign_err, bus_err, stall_if, stall_mem}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // No requests: bus stays idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_bus_req", {31'd0, bus.bus_req}, 32'd0);
        end

        // Single IF fetch with minimum latency
        lat = 0;
        n = cyc + 1;
        req_if(n, 32'h0000_1006);
        exp_bus_push(32'h0000_1004, 1'b0, 4'b1111, 32'd0, 32'hDEAD_BEEF);
        exp_if.push_back(mk_rsp(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, n + 2));
        to_neg(n);
        chk("fetch_stall_if_pending", {31'd0, stall_if}, 32'd1);
        to_neg(n + 1);
        chk("fetch_bus_req_c1", {31'd0, bus.bus_req}, 32'd1);
        to_neg(n + 2);
        chk("fetch_stall_if_done", {31'd0, stall_if}, 32'd0);
        drain();

        // Simultaneous MEM load and IF fetch: MEM first, gapless hand-over
        n = cyc + 1;
        req_if(n, 32'h0000_0300);
        req_mem(n, 32'h0000_0200, 1'b0, 32'd0, 2'b10);
        exp_bus_push(32'h0000_0200, 1'b0, 4'b1111, 32'd0, 32'h1111_2222);
        exp_bus_push(32'h0000_0300, 1'b0, 4'b1111, 32'd0, 32'h3333_4444);
        exp_mem.push_back(mk_rsp(32'h1111_2222, 1'b1, 1'b0, 1'b0, n + 2));
        exp_if.push_back(mk_rsp(32'h3333_4444, 1'b1, 1'b0, 1'b0, n + 3));
        to_neg(n + 1);
        chk("b2b_bus_req_c1", {31'd0, bus.bus_req}, 32'd1);
        to_neg(n + 2);
        chk("b2b_bus_req_c2", {31'd0, bus.bus_req}, 32'd1);
        to_neg(n + 3);
        chk("b2b_bus_req_c3", {31'd0, bus.bus_req}, 32'd0);
        drain();

        // Two wait states; a second MEM request arriving mid-IF waits for IF
        lat = 2;
        n = cyc + 1;
        req_if(n, 32'h0000_0308);
        req_mem(n, 32'h0000_0200, 1'b0, 32'd0, 2'b10);
        req_mem(n + 6, 32'h0000_0204, 1'b0, 32'd0, 2'b10);
        exp_bus_push(32'h0000_0200, 1'b0, 4'b1111, 32'd0, 32'h5555_0001);
        exp_bus_push(32'h0000_0308, 1'b0, 4'b1111, 32'd0, 32'h6666_0002);
        exp_bus_push(32'h0000_0204, 1'b0, 4'b1111, 32'd0, 32'h7777_0003);
        exp_mem.push_back(mk_rsp(32'h5555_0001, 1'b1, 1'b0, 1'b0, n + 4));
        exp_if.push_back(mk_rsp(32'h6666_0002, 1'b1, 1'b0, 1'b0, n + 7));
        exp_mem.push_back(mk_rsp(32'h7777_0003, 1'b1, 1'b0, 1'b0, n + 10));
        lows = 0;
        for (int k = 1; k <= 9; k++) begin
            to_neg(n + k);
            if (!bus.bus_req) lows++;
        end
        chk("wait_b2b_bus_req_low_cycles", lows, 32'd0);
        to_neg(n + 10);
        chk("wait_b2b_bus_req_end", {31'd0, bus.bus_req}, 32'd0);
        drain();
        lat = 0;

        // Aligned stores and loads: byte enables and lane replication
        for (int i = 0; i < 7; i++) begin
            n = cyc + 1;
            req_mem(n, t_addr[i], t_we[i], t_wd[i], t_sz[i]);
            exp_bus_push({t_addr[i][31:2], 2'b00}, t_we[i], t_be[i], t_bwd[i], 32'h5A5A_0000 + i);
            exp_mem.push_back(mk_rsp(32'h5A5A_0000 + i, 1'b1, 1'b0, 1'b0, n + 2));
            drain();
        end

        // Misaligned accesses: no bus cycle, done + misalign_err next cycle
        for (int i = 0; i < 4; i++) begin
            n = cyc + 1;
            req_mem(n, m_addr[i], m_we[i], 32'h0BAD_0BAD, m_sz[i]);
            exp_mem.push_back(mk_rsp(32'd0, 1'b0, 1'b1, 1'b0, n + 1));
            to_neg(n + 1);
            chk("misalign_no_bus_req", {31'd0, bus.bus_req}, 32'd0);
            drain();
        end

`ifdef ARB_TIMEOUT_EN
        // Timeout: bus_req drops after 4 wait cycles, done with bus_err and rdata 0
        never_ready = 1'b1;
        n = cyc + 1;
        req_if(n, 32'h0000_0400);
        exp_if.push_back(mk_rsp(32'd0, 1'b1, 1'b0, 1'b1, n + 5));
        to_neg(n + 4);
        chk("timeout_bus_req_last_wait", {31'd0, bus.bus_req}, 32'd1);
        to_neg(n + 5);
        chk("timeout_bus_req_dropped", {31'd0, bus.bus_req}, 32'd0);
        drain();
        never_ready = 1'b0;

        n = cyc + 1;
        never_ready = 1'b1;
        req_if(n, 32'h0000_0500);
        to_neg(n + 2);
`else
        // No timeout: an unanswered access holds the bus indefinitely
        never_ready = 1'b1;
        n = cyc + 1;
        req_if(n, 32'h0000_0500);
        lows = 0;
        for (int k = 1; k <= 100; k++) begin
            to_neg(n + k);
            if (!bus.bus_req) lows++;
        end
        chk("hold_bus_req_low_cycles", lows, 32'd0);
        chk("hold_no_bus_err", {31'd0, bus_err}, 32'd0);
`endif

        // Reset mid-access: bus_req falls immediately, no done, access lost
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_bus_req_async", {31'd0, bus.bus_req}, 32'd0);
        chk("midrst_if_done", {31'd0, if_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        never_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_bus_req_after", {31'd0, bus.bus_req}, 32'd0);
        chk("midrst_if_rdata_cleared", if_rdata, 32'd0);

        // Arbiter still works after the aborted access
        n = cyc + 1;
        req_if(n, 32'h0000_2002);
        exp_bus_push(32'h0000_2000, 1'b0, 4'b1111, 32'd0, 32'h0123_4567);
        exp_if.push_back(mk_rsp(32'h0123_4567, 1'b1, 1'b0, 1'b0, n + 2));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory bus between the IF stage (instruction fetch) and the MEM stage (load/store), downstream of the EX/MEM pipeline register. Grants one requester at a time with MEM priority and runs a ready-handshake with the memory. Generates byte enables and lane-aligned store data, and returns raw read words and one-cycle completion pulses. Drives the per-stage stall signals that hold the pipeline registers while an access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles without `bus_ready` before a granted access is aborted (only with `ARB_TIMEOUT_EN`); must be ≥1.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: IF wants a word read at `if_addr`; held until `if_done`.
- `if_addr` in 32: fetch address; bits [1:0] ignored.
- `mem_req` in 1: MEM wants an access; held until `mem_done`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data, right-aligned.
- `mem_size` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `bus_ready` in 1: memory completes current access this cycle.
- `bus_rdata` in 32: read word, valid when `bus_ready`=1.
- `bus_req` out 1: access in progress (registered).
- `bus_we` out 1: write strobe.
- `bus_addr` out 32: word-aligned address ([1:0]=00).
- `bus_wdata` out 32: lane-aligned store data.
- `bus_be` out 4: byte enables; 1111 for all reads.
- `if_done` out 1: one-cycle pulse, IF access complete.
- `if_rdata` out 32: fetched word, valid with `if_done`, held after.
- `mem_done` out 1: one-cycle pulse, MEM access complete (load or store).
- `mem_rdata` out 32: raw load word (unshifted), valid with `mem_done`, held after.
- `misalign_err` out 1: one-cycle pulse with `mem_done` for a misaligned MEM access.
- `bus_err` out 1: one-cycle pulse with the done pulse of an aborted access.
- `stall_if` out 1: combinational, `if_req & ~if_done`.
- `stall_mem` out 1: combinational, `mem_req & ~mem_done`.

## Operation
- FSM states: IDLE, GNT_IF, GNT_MEM.
- IDLE:
  - `mem_req`=1 and aligned: latch request fields, go GNT_MEM.
  - `mem_req`=1 and misaligned (half with addr[0]=1; word with addr[1:0]≠00): no bus access; next cycle pulse `mem_done` and `misalign_err`; stay IDLE.
  - Otherwise `if_req`=1: latch `if_addr`, go GNT_IF.
- GNT_x: `bus_req`=1, bus fields stable from the latched request until `bus_ready` is sampled high.
- On `bus_ready`:
  - Capture `bus_rdata` into the requester's rdata register; pulse its done next cycle.
  - Re-arbitrate in the same cycle with the just-served requester masked; if the other is pending, grant it directly with no idle cycle, otherwise go IDLE.
- MEM has priority in IDLE. The completion mask guarantees IF is served between two back-to-back MEM accesses, so neither requester starves.
- Byte enables: byte = 0001<<addr[1:0]; half = 0011<<(2·addr[1]); word = 1111.
- Write data: `bus_wdata` = `mem_wdata` replicated to the lane, i.e. byte `{4{wdata[7:0]}}` and half `{2{wdata[15:0]}}`.
- Read data is never shifted; load extension is done downstream.
- Requests seen in the pulse cycle of their own done are not re-serviced; the requester deasserts after its done.

## Timing
- Minimum latency: request in IDLE at cycle 0 → `bus_req` at cycle 1 → with `bus_ready` at 1, done at cycle 2.
- Each wait cycle (`bus_ready`=0) adds one cycle.
- Back-to-back grant: the next requester's `bus_req` stays high continuously; its access starts the cycle after the previous `bus_ready`.
- Misaligned access: done plus `misalign_err` 1 cycle after the request; `bus_req` stays 0.
- Reset values:
  - All outputs 0, state IDLE.
  - `if_rdata`/`mem_rdata` = 0.
  - Stall outputs follow their equations.
- Reset asserted mid-access: `bus_req` drops asynchronously, no done is issued, and the pending access is lost.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on grant and increments each GNT cycle with `bus_ready`=0.
  - On reaching `TIMEOUT_CYCLES`, `bus_req` drops and the next cycle pulses the requester's done with `bus_err`=1 and rdata=0. Arbitration then continues as on normal completion.
- Not defined: no counter; waits indefinitely; `bus_err` tied 0.

## Test plan
- Reset → all outputs 0; release with no requests → `bus_req` stays 0 for 10 cycles.
- `if_req`, `if_addr`=0x0000_1006, ready same cycle, rdata 0xDEADBEEF → `bus_addr`=0x0000_1004, `be`=1111, `if_done` at cycle 2 with `if_rdata`=0xDEADBEEF.
- `if_req`+`mem_req` together (load 0x200):
  - MEM is granted first, IF immediately after with `bus_req` continuously high.
  - `mem_done` precedes `if_done` by 1 cycle with ready=1.
  - A second `mem_req` arriving mid-way still waits for IF.
- Byte store: `wdata`=0x0000_00A5, addr 0x103 → `be`=1000, `bus_wdata`=0xA5A5A5A5, `we`=1. Half store at 0x102 → `be`=1100.
- Word load at 0x101 → no `bus_req`; `mem_done`+`misalign_err` 1 cycle later.
- `ARB_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4 and `bus_ready` held 0 → `bus_req` drops after 4 wait cycles; `bus_err`+`if_done` pulse with rdata 0. Without the macro → `bus_req` holds 100 cycles.
